lstm_gate_seq: RTL and testbench

- Sequencer for one LSTM gate neuron: a tanh or sigmoid activation unit with per-cell weight/bias RAM, addressed by rd_addr/wr_addr with a wr strobe.
- Forward pass: steps the read address over all NUM_LSTM cells, waits for the combinational datapath to settle, and captures each activation into an output vector.
- Update pass: issues one write strobe per cell address so that upstream backprop logic can commit new weights and bias.
- Sits between the layer-level control FSM and the gate datapath. One instance per gate.

---
 rtl/lstm_gate_seq.sv | 169 ++++++++++++++++
 tb/tb_lstm_gate_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lstm_gate_seq.sv
// Sequencer for one LSTM gate neuron. Steps the shared gate datapath over
// all cells for a forward pass (capturing each activation), or issues one
// write strobe per cell for a weight/bias update pass.
module lstm_gate_seq #(
  parameter int unsigned NUM_LSTM = 8,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SETTLE   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_upd,
  input  logic [WIDTH-1:0]          i_a,
  output logic [8:0]                o_rd_addr,
  output logic [8:0]                o_wr_addr,
  output logic                      o_wr,
  output logic [NUM_LSTM*WIDTH-1:0] o_a_vec,
  output logic                      o_valid,
  output logic                      o_upd_done,
  output logic                      o_busy,
  output logic                      o_overrun
);

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned VEC_W  = NUM_LSTM * WIDTH;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LSTM - 1);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DONE = 2'd2,
    UPD  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               upd_pend, upd_pend_n;

  // Next values of the registered outputs
  logic [ADDR_W-1:0]  rd_addr_n;
  logic [ADDR_W-1:0]  wr_addr_n;
  logic               wr_n;
  logic [VEC_W-1:0]   a_vec_n;
  logic               valid_n;
  logic               upd_done_n;
  logic               busy_n;
  logic               overrun_n;
  logic               capture;
  logic               upd_take;

  // State, counters and all outputs registered together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      upd_pend   <= 1'b0;
      o_rd_addr  <= '0;
      o_wr_addr  <= '0;
      o_wr       <= 1'b0;
      o_a_vec    <= '0;
      o_valid    <= 1'b0;
      o_upd_done <= 1'b0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      upd_pend   <= upd_pend_n;
      o_rd_addr  <= rd_addr_n;
      o_wr_addr  <= wr_addr_n;
      o_wr       <= wr_n;
      o_a_vec    <= a_vec_n;
      o_valid    <= valid_n;
      o_upd_done <= upd_done_n;
      o_busy     <= busy_n;
      o_overrun  <= overrun_n;
    end
  end

  // Next-state and next-output logic; outputs reflect the state being entered
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    cnt_n      = cnt;
    rd_addr_n  = '0;
    wr_addr_n  = '0;
    wr_n       = 1'b0;
    valid_n    = 1'b0;
    upd_done_n = 1'b0;
    capture    = 1'b0;
    upd_take   = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_n = FWD;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (upd_pend) begin
          state_n   = UPD;
          idx_n     = '0;
          upd_take  = 1'b1;
          wr_n      = 1'b1;
          wr_addr_n = '0;
        end
      end

      FWD: begin
        if (cnt == SETTLE_CNT) begin
          capture = 1'b1;
          cnt_n   = '0;
          if (idx == LAST_IDX) begin
            state_n = DONE;
            valid_n = 1'b1;
          end else begin
            idx_n     = idx + IDX_W'(1);
            rd_addr_n = ADDR_W'(idx + IDX_W'(1));
          end
        end else begin
          cnt_n     = cnt + CNT_W'(1);
          rd_addr_n = ADDR_W'(idx);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      UPD: begin
        if (idx == LAST_IDX) begin
          state_n    = IDLE;
          idx_n      = '0;
          upd_done_n = 1'b1;
        end else begin
          idx_n     = idx + IDX_W'(1);
          wr_n      = 1'b1;
          wr_addr_n = ADDR_W'(idx + IDX_W'(1));
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // A request arriving in the consuming cycle survives the consume
    upd_pend_n = (upd_take ? 1'b0 : upd_pend) | i_upd;
    overrun_n  = o_overrun | (i_start && (state != IDLE));
    busy_n     = (state_n != IDLE);
  end

  // Slot-wise capture of the settled activation into the output vector
  always_comb begin
    a_vec_n = o_a_vec;
    for (int unsigned k = 0; k < NUM_LSTM; k++) begin
      if (capture && (idx == IDX_W'(k))) begin
        a_vec_n[k*WIDTH +: WIDTH] = i_a;
      end
    end
  end

endmodule

// File: tb/tb_lstm_gate_seq.sv
// Directed bench for lstm_gate_seq: an 8-cell/SETTLE=2 instance driven by a
// datapath model returning 0x100*rd_addr, plus a 1-cell/SETTLE=0 instance.
module tb_lstm_gate_seq;

  logic          clk;
  logic          rst;
  logic          i_start, i_upd;
  logic [31:0]   i_a;
  logic [8:0]    o_rd_addr, o_wr_addr;
  logic          o_wr, o_valid, o_upd_done, o_busy, o_overrun;
  logic [255:0]  o_a_vec;

  logic          s1_start, s1_upd;
  logic [31:0]   s1_a;
  logic [8:0]    s1_rd_addr, s1_wr_addr;
  logic          s1_wr, s1_valid, s1_upd_done, s1_busy, s1_overrun;
  logic [31:0]   s1_a_vec;

  int n_cmp;
  int n_err;

  lstm_gate_seq #(.NUM_LSTM(8), .WIDTH(32), .SETTLE(2)) u_dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_upd(i_upd), .i_a(i_a),
    .o_rd_addr(o_rd_addr), .o_wr_addr(o_wr_addr), .o_wr(o_wr),
    .o_a_vec(o_a_vec), .o_valid(o_valid), .o_upd_done(o_upd_done),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  lstm_gate_seq #(.NUM_LSTM(1), .WIDTH(32), .SETTLE(0)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(s1_start), .i_upd(s1_upd), .i_a(s1_a),
    .o_rd_addr(s1_rd_addr), .o_wr_addr(s1_wr_addr), .o_wr(s1_wr),
    .o_a_vec(s1_a_vec), .o_valid(s1_valid), .o_upd_done(s1_upd_done),
    .o_busy(s1_busy), .o_overrun(s1_overrun)
  );

  // Datapath models
  assign i_a  = 32'h100 * {23'd0, o_rd_addr};
  assign s1_a = 32'hABCD_1234;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Called in the cycle right after the start edge; optional start re-pulse
  task automatic fwd_pass(input int pulse_at);
    for (int j = 0; j < 24; j++) begin
      check("fwd_rd_addr", 64'(o_rd_addr), 64'(j / 3));
      check("fwd_wr", 64'(o_wr), 64'd0);
      check("fwd_valid_low", 64'(o_valid), 64'd0);
      check("fwd_busy", 64'(o_busy), 64'd1);
      if (j == pulse_at) i_start = 1'b1;
      step();
      i_start = 1'b0;
    end
    check("fwd_valid_pulse", 64'(o_valid), 64'd1);
    for (int k = 0; k < 8; k++) begin
      check("fwd_slot", 64'(o_a_vec[k*32 +: 32]), 64'(32'h100 * k));
    end
    step();
    check("fwd_valid_drop", 64'(o_valid), 64'd0);
    check("fwd_busy_drop", 64'(o_busy), 64'd0);
  endtask

  // Called in the cycle the first strobe is visible
  task automatic upd_pass();
    for (int k = 0; k < 8; k++) begin
      check("upd_wr", 64'(o_wr), 64'd1);
      check("upd_wr_addr", 64'(o_wr_addr), 64'(k));
      check("upd_rd_addr", 64'(o_rd_addr), 64'd0);
      check("upd_done_low", 64'(o_upd_done), 64'd0);
      step();
    end
    check("upd_wr_drop", 64'(o_wr), 64'd0);
    check("upd_wr_addr_zero", 64'(o_wr_addr), 64'd0);
    check("upd_done_pulse", 64'(o_upd_done), 64'd1);
    check("upd_busy_drop", 64'(o_busy), 64'd0);
    step();
    check("upd_done_drop", 64'(o_upd_done), 64'd0);
    check("upd_wr_idle", 64'(o_wr), 64'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    i_start  = 1'b0;
    i_upd    = 1'b0;
    s1_start = 1'b0;
    s1_upd   = 1'b0;
    step();
    step();

    // Reset state
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_wr", 64'(o_wr), 64'd0);
    check("rst_rd_addr", 64'(o_rd_addr), 64'd0);
    check("rst_vec", 64'(o_a_vec[63:0]), 64'd0);
    check("rst_overrun", 64'(o_overrun), 64'd0);
    check("rst_s1_busy", 64'(s1_busy), 64'd0);
    rst = 1'b0;
    step();

    // Plain forward pass
    start_pulse();
    fwd_pass(-1);
    check("fwd_overrun_clear", 64'(o_overrun), 64'd0);

    // Plain update pass from IDLE
    i_upd = 1'b1;
    step();
    i_upd = 1'b0;
    check("upd_pending_no_wr", 64'(o_wr), 64'd0);
    step();
    upd_pass();

    // Start and update together: forward first, then update
    i_start = 1'b1;
    i_upd   = 1'b1;
    step();
    i_start = 1'b0;
    i_upd   = 1'b0;
    fwd_pass(-1);
    step();
    upd_pass();

    // Start re-pulsed mid-pass: ignored, overrun set
    start_pulse();
    fwd_pass(10);
    check("ovr_set", 64'(o_overrun), 64'd1);
    for (int j = 0; j < 5; j++) begin
      check("ovr_no_second_pass", 64'(o_busy), 64'd0);
      step();
    end
    check("ovr_sticky", 64'(o_overrun), 64'd1);

    // Reset mid forward pass
    start_pulse();
    for (int j = 0; j < 13; j++) step();
    check("pre_rst_slot3", 64'(o_a_vec[127:96]), 64'h300);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(o_busy), 64'd0);
    check("rst_mid_rd_addr", 64'(o_rd_addr), 64'd0);
    check("rst_mid_slot1", 64'(o_a_vec[63:32]), 64'd0);
    check("rst_mid_slot3", 64'(o_a_vec[127:96]), 64'd0);
    check("rst_mid_overrun", 64'(o_overrun), 64'd0);
    step();
    rst = 1'b0;
    for (int j = 0; j < 30; j++) begin
      check("rst_no_valid", 64'(o_valid), 64'd0);
      step();
    end
    start_pulse();
    fwd_pass(-1);

    // Single cell, no settle
    s1_start = 1'b1;
    step();
    s1_start = 1'b0;
    check("s1_busy", 64'(s1_busy), 64'd1);
    check("s1_valid_low", 64'(s1_valid), 64'd0);
    step();
    check("s1_valid", 64'(s1_valid), 64'd1);
    check("s1_vec", 64'(s1_a_vec), 64'hABCD_1234);
    step();
    check("s1_valid_drop", 64'(s1_valid), 64'd0);
    check("s1_idle", 64'(s1_busy), 64'd0);
    s1_upd = 1'b1;
    step();
    s1_upd = 1'b0;
    check("s1_upd_pending", 64'(s1_wr), 64'd0);
    step();
    check("s1_wr", 64'(s1_wr), 64'd1);
    check("s1_wr_addr", 64'(s1_wr_addr), 64'd0);
    step();
    check("s1_wr_drop", 64'(s1_wr), 64'd0);
    check("s1_upd_done", 64'(s1_upd_done), 64'd1);
    step();
    check("s1_no_second_wr", 64'(s1_wr), 64'd0);
    check("s1_upd_done_drop", 64'(s1_upd_done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
